gemm_job_scheduler: RTL and testbench

//  Queues GeMM job descriptors (id, M, K, N) from the host side and runs them one at a time on gemm_controller.
//  For each job it pulses start, holds the sizes stable and waits for done.
//  It then returns a completion record (id, error flag, cycle count) through a valid/ready port.

---
 rtl/gemm_job_scheduler.sv | 160 ++++++++++++++++
 tb/tb_gemm_job_scheduler.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_job_scheduler.sv
// GeMM job scheduler: queues (id, M, K, N) descriptors, launches them one at a
// time on gemm_controller, and returns a completion record for each one.
// Jobs whose sizes are not whole 4x4x4 tiles are reported as errors and never launched.
module gemm_job_scheduler #(
   parameter int unsigned AddrWidth     = 16,
   parameter int unsigned QueueDepth    = 4,
   parameter int unsigned JobIdWidth    = 4,
   parameter int unsigned CycleCntWidth = 32
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             job_valid_i,
   output logic                             job_ready_o,
   input  logic [JobIdWidth-1:0]            job_id_i,
   input  logic [AddrWidth-1:0]             job_M_i,
   input  logic [AddrWidth-1:0]             job_K_i,
   input  logic [AddrWidth-1:0]             job_N_i,
   output logic                             ctrl_start_o,
   output logic [AddrWidth-1:0]             ctrl_M_size_o,
   output logic [AddrWidth-1:0]             ctrl_K_size_o,
   output logic [AddrWidth-1:0]             ctrl_N_size_o,
   input  logic                             ctrl_busy_i,
   input  logic                             ctrl_done_i,
   output logic                             cmpl_valid_o,
   input  logic                             cmpl_ready_i,
   output logic [JobIdWidth-1:0]            cmpl_id_o,
   output logic                             cmpl_err_o,
   output logic [CycleCntWidth-1:0]         cmpl_cycles_o,
   output logic [$clog2(QueueDepth+1)-1:0]  queue_level_o,
   output logic                             idle_o
);

   localparam int unsigned PtrWidth = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
   localparam int unsigned LvlWidth = $clog2(QueueDepth + 1);

   typedef struct packed {
      logic [JobIdWidth-1:0] id;
      logic [AddrWidth-1:0]  m;
      logic [AddrWidth-1:0]  k;
      logic [AddrWidth-1:0]  n;
   } job_t;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StLaunch = 2'd1,
      StWait   = 2'd2,
      StReport = 2'd3
   } state_e;

   state_e                   r_state;
   state_e                   w_state_nxt;
   job_t                     r_mem [QueueDepth];
   logic [PtrWidth-1:0]      r_wr_ptr;
   logic [PtrWidth-1:0]      r_rd_ptr;
   logic [LvlWidth-1:0]      r_level;
   job_t                     r_active;
   logic                     r_err;
   logic [CycleCntWidth-1:0] r_cycles;

   job_t w_head;
   job_t w_in;
   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_head_ok;

   // A size is executable when it is non-zero and a whole number of 4-wide tiles
   function automatic logic size_ok(input logic [AddrWidth-1:0] s);
      return (s != '0) && (s[1:0] == 2'b00);
   endfunction

   assign w_in      = '{id: job_id_i, m: job_M_i, k: job_K_i, n: job_N_i};
   assign w_head    = r_mem[r_rd_ptr];
   assign w_full    = (r_level == LvlWidth'(QueueDepth));
   assign w_empty   = (r_level == '0);
   assign w_push    = job_valid_i & job_ready_o;
   assign w_head_ok = size_ok(w_head.m) & size_ok(w_head.k) & size_ok(w_head.n);

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_state <= StIdle;
      else         r_state <= w_state_nxt;
   end

   // Next-state logic and pop decision
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         StIdle: begin
            if (!w_empty && !ctrl_busy_i) begin
               w_pop       = 1'b1;
               w_state_nxt = w_head_ok ? StLaunch : StReport;
            end
         end
         StLaunch: w_state_nxt = StWait;
         StWait:   if (ctrl_done_i) w_state_nxt = StReport;
         StReport: if (cmpl_ready_i) w_state_nxt = StIdle;
         default:  w_state_nxt = StIdle;
      endcase
   end

   // Descriptor FIFO: storage, pointers and occupancy
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < QueueDepth; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_in;
            r_wr_ptr        <= r_wr_ptr + PtrWidth'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PtrWidth'(1);
         if (w_push && !w_pop)      r_level <= r_level + LvlWidth'(1);
         else if (!w_push && w_pop) r_level <= r_level - LvlWidth'(1);
      end
   end

   // Active job registers, error flag and saturating wait-cycle counter
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_active <= '0;
         r_err    <= 1'b0;
         r_cycles <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_pop) begin
                  r_active <= w_head;
                  r_err    <= ~w_head_ok;
                  r_cycles <= '0;
               end
            end
            StLaunch: r_cycles <= '0;
            StWait: begin
               if (r_cycles != '1) r_cycles <= r_cycles + CycleCntWidth'(1);
               if (ctrl_done_i)    r_err    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Outputs are forced low for as long as reset is held
   assign job_ready_o   = rst_ni & ~w_full;
   assign ctrl_start_o  = rst_ni & (r_state == StLaunch);
   assign ctrl_M_size_o = rst_ni ? r_active.m : '0;
   assign ctrl_K_size_o = rst_ni ? r_active.k : '0;
   assign ctrl_N_size_o = rst_ni ? r_active.n : '0;
   assign cmpl_valid_o  = rst_ni & (r_state == StReport);
   assign cmpl_id_o     = rst_ni ? r_active.id : '0;
   assign cmpl_err_o    = rst_ni & r_err;
   assign cmpl_cycles_o = rst_ni ? r_cycles : '0;
   assign queue_level_o = rst_ni ? r_level : '0;
   assign idle_o        = rst_ni & (r_state == StIdle) & w_empty;

endmodule

// File: tb/tb_gemm_job_scheduler.sv
// Scoreboard bench for gemm_job_scheduler with a mock gemm_controller.
module tb_gemm_job_scheduler;

   localparam int AW = 16;
   localparam int QD = 4;
   localparam int IW = 4;
   localparam int CW = 32;
   localparam int LW = $clog2(QD + 1);

   logic          clk = 1'b0;
   logic          rst_ni;
   logic          job_valid_i;
   logic          job_ready_o;
   logic [IW-1:0] job_id_i;
   logic [AW-1:0] job_M_i, job_K_i, job_N_i;
   logic          ctrl_start_o;
   logic [AW-1:0] ctrl_M_size_o, ctrl_K_size_o, ctrl_N_size_o;
   logic          ctrl_busy_i, ctrl_done_i;
   logic          cmpl_valid_o, cmpl_ready_i;
   logic [IW-1:0] cmpl_id_o;
   logic          cmpl_err_o;
   logic [CW-1:0] cmpl_cycles_o;
   logic [LW-1:0] queue_level_o;
   logic          idle_o;

   logic mock_busy, mock_done, hold_busy, rdy_hold, rdy_always;

   assign ctrl_busy_i = mock_busy | hold_busy;
   assign ctrl_done_i = mock_done;

   always #5 clk = ~clk;

   gemm_job_scheduler #(
      .AddrWidth(AW), .QueueDepth(QD), .JobIdWidth(IW), .CycleCntWidth(CW)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_id_i(job_id_i),
      .job_M_i(job_M_i), .job_K_i(job_K_i), .job_N_i(job_N_i),
      .ctrl_start_o(ctrl_start_o), .ctrl_M_size_o(ctrl_M_size_o),
      .ctrl_K_size_o(ctrl_K_size_o), .ctrl_N_size_o(ctrl_N_size_o),
      .ctrl_busy_i(ctrl_busy_i), .ctrl_done_i(ctrl_done_i),
      .cmpl_valid_o(cmpl_valid_o), .cmpl_ready_i(cmpl_ready_i), .cmpl_id_o(cmpl_id_o),
      .cmpl_err_o(cmpl_err_o), .cmpl_cycles_o(cmpl_cycles_o),
      .queue_level_o(queue_level_o), .idle_o(idle_o)
   );

   typedef struct {
      int id;
      int m;
      int k;
      int n;
   } desc_t;

   desc_t exp_q[$];
   int    delay_q[$];
   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   int    n_starts = 0;
   int    force_delay = 0;
   int    last_accept_cyc = 0;
   int    last_start_cyc = 0;
   int    last_cmpl_err = 0;
   int    last_cmpl_cycles = 0;

   function automatic bit legal(input int v);
      return (v > 0) && (v % 4 == 0);
   endfunction

   function automatic int rnd_size();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return 0;
      if (r == 1) return int'($urandom_range(1, 40));
      return 4 * int'($urandom_range(1, 16));
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic send_job(input int id, input int m, input int k, input int n);
      int guard;
      guard = 0;
      @(posedge clk); #1;
      job_valid_i = 1'b1;
      job_id_i    = IW'(id);
      job_M_i     = AW'(m);
      job_K_i     = AW'(k);
      job_N_i     = AW'(n);
      forever begin
         @(negedge clk);
         if (job_ready_o) break;
         guard++;
         if (guard > 3000) begin
            check("accept_timeout", 1, 0);
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      job_valid_i = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int t;
      t = 0;
      forever begin
         @(negedge clk);
         if (exp_q.size() == 0 && idle_o) break;
         t++;
         if (t > budget) begin
            check("drain_timeout", 1, 0);
            break;
         end
      end
   endtask

   // Cycle counter
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Accept monitor: every handshake becomes an expected completion
   initial forever begin
      @(negedge clk);
      if (rst_ni && job_valid_i && job_ready_o) begin
         exp_q.push_back('{id: int'(job_id_i), m: int'(job_M_i), k: int'(job_K_i), n: int'(job_N_i)});
         last_accept_cyc = cyc;
      end
   end

   // Launch monitor: only the oldest outstanding job may start, and only if legal
   initial forever begin
      desc_t d;
      @(negedge clk);
      if (ctrl_start_o) begin
         n_starts++;
         last_start_cyc = cyc;
         if (exp_q.size() == 0) check("start_unexpected", 1, 0);
         else begin
            d = exp_q[0];
            check("start_legal", longint'(legal(d.m) && legal(d.k) && legal(d.n)), 1);
            check("start_M", ctrl_M_size_o, d.m);
            check("start_K", ctrl_K_size_o, d.k);
            check("start_N", ctrl_N_size_o, d.n);
         end
      end
   end

   // Completion monitor: scoreboard pop on handshake, stability while stalled
   initial begin
      bit pv, ptaken;
      logic [IW-1:0] p_id;
      logic p_err;
      logic [CW-1:0] p_cyc;
      desc_t d;
      int exp_cycles;
      pv = 0; ptaken = 0; p_id = '0; p_err = 0; p_cyc = '0;
      forever begin
         @(negedge clk);
         if (cmpl_valid_o) begin
            if (pv && !ptaken) begin
               check("cmpl_stable_id", cmpl_id_o, p_id);
               check("cmpl_stable_err", cmpl_err_o, p_err);
               check("cmpl_stable_cycles", cmpl_cycles_o, p_cyc);
            end
            p_id = cmpl_id_o; p_err = cmpl_err_o; p_cyc = cmpl_cycles_o;
            ptaken = cmpl_ready_i;
            if (cmpl_ready_i) begin
               if (exp_q.size() == 0) check("cmpl_unexpected", 1, 0);
               else begin
                  d = exp_q.pop_front();
                  if (legal(d.m) && legal(d.k) && legal(d.n)) begin
                     if (delay_q.size() == 0) begin
                        check("cmpl_no_launch", 1, 0);
                        exp_cycles = -1;
                     end else exp_cycles = delay_q.pop_front();
                     check("cmpl_err", cmpl_err_o, 0);
                  end else begin
                     exp_cycles = 0;
                     check("cmpl_err", cmpl_err_o, 1);
                  end
                  check("cmpl_id", cmpl_id_o, d.id);
                  check("cmpl_cycles", cmpl_cycles_o, exp_cycles);
               end
               last_cmpl_err    = int'(cmpl_err_o);
               last_cmpl_cycles = int'(cmpl_cycles_o);
            end
         end
         pv = cmpl_valid_o;
      end
   end

   // Mock controller: busy after start, done in the chosen Wait cycle
   initial begin
      int d;
      mock_busy = 1'b0;
      mock_done = 1'b0;
      forever begin
         @(negedge clk);
         if (ctrl_start_o) begin
            d = (force_delay != 0) ? force_delay : int'($urandom_range(1, 12));
            delay_q.push_back(d);
            @(posedge clk); #1;
            mock_busy = 1'b1;
            repeat (d - 1) begin
               @(posedge clk); #1;
            end
            mock_done = 1'b1;
            @(posedge clk); #1;
            mock_done = 1'b0;
            mock_busy = 1'b0;
         end
      end
   end

   // Completion consumer
   initial forever begin
      @(posedge clk); #1;
      cmpl_ready_i = rdy_hold ? 1'b0 : (rdy_always ? 1'b1 : ($urandom_range(0, 3) != 0));
   end

   // Global time limit
   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   // Main stimulus
   initial begin
      int s;
      int g;
      rst_ni = 1'b0; job_valid_i = 1'b0; job_id_i = '0;
      job_M_i = '0; job_K_i = '0; job_N_i = '0;
      hold_busy = 1'b0; rdy_hold = 1'b0; rdy_always = 1'b1; cmpl_ready_i = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs_zero", |{job_ready_o, ctrl_start_o, ctrl_M_size_o, ctrl_K_size_o,
            ctrl_N_size_o, cmpl_valid_o, cmpl_id_o, cmpl_err_o, cmpl_cycles_o, queue_level_o, idle_o}, 0);
      @(posedge clk); #1;
      rst_ni = 1'b1;
      @(negedge clk);
      check("post_reset_ready", job_ready_o, 1);
      check("post_reset_idle", idle_o, 1);
      check("post_reset_level", queue_level_o, 0);

      // Legal 4x4x4 job, done in the 10th Wait cycle
      force_delay = 10;
      send_job(3, 4, 4, 4);
      wait_drain(200);
      check("t1_start_latency", last_start_cyc - last_accept_cyc, 2);
      check("t1_cycles", last_cmpl_cycles, 10);

      // Illegal K: reported, never launched
      s = n_starts;
      send_job(5, 4, 6, 4);
      wait_drain(200);
      check("t2_no_start", n_starts, s);
      check("t2_err", last_cmpl_err, 1);

      // Busy controller: FIFO fills to capacity, then drains in order
      force_delay = 0;
      hold_busy = 1'b1;
      s = n_starts;
      for (int i = 0; i < 4; i++) send_job(i, 8, 4, 12);
      @(posedge clk); #1;
      job_valid_i = 1'b1; job_id_i = IW'(4);
      job_M_i = AW'(4); job_K_i = AW'(8); job_N_i = AW'(4);
      repeat (3) @(negedge clk);
      check("t3_level_full", queue_level_o, 4);
      check("t3_ready_low", job_ready_o, 0);
      check("t3_no_start", n_starts, s);
      @(posedge clk); #1;
      hold_busy = 1'b0;
      g = 0;
      forever begin
         @(negedge clk);
         if (job_ready_o) break;
         g++;
         if (g > 500) begin
            check("t3_accept_timeout", 1, 0);
            break;
         end
      end
      @(posedge clk); #1;
      job_valid_i = 1'b0;
      wait_drain(500);

      // Completion back-pressure: record held, no new launch, FIFO still accepts
      force_delay = 3;
      rdy_hold = 1'b1;
      send_job(9, 4, 8, 4);
      g = 0;
      while (!cmpl_valid_o && g < 200) begin
         @(negedge clk);
         g++;
      end
      check("t4_cmpl_valid", cmpl_valid_o, 1);
      s = n_starts;
      send_job(10, 4, 4, 4);
      repeat (20) @(negedge clk);
      check("t4_level", queue_level_o, 1);
      check("t4_no_start", n_starts, s);
      check("t4_still_valid", cmpl_valid_o, 1);
      rdy_hold = 1'b0;
      wait_drain(200);

      // Simultaneous push and pop at level 2
      hold_busy = 1'b1;
      send_job(1, 4, 4, 4);
      send_job(2, 4, 4, 8);
      @(posedge clk); #1;
      hold_busy = 1'b0;
      job_valid_i = 1'b1; job_id_i = IW'(3);
      job_M_i = AW'(8); job_K_i = AW'(4); job_N_i = AW'(4);
      @(negedge clk);
      check("t5_ready", job_ready_o, 1);
      @(posedge clk); #1;
      job_valid_i = 1'b0;
      @(negedge clk);
      check("t5_level", queue_level_o, 2);
      wait_drain(300);

      // Reset in the middle of Wait abandons the job
      force_delay = 40;
      s = n_starts;
      send_job(7, 4, 4, 4);
      g = 0;
      while (n_starts == s && g < 100) begin
         @(negedge clk);
         g++;
      end
      check("t6_started", n_starts, s + 1);
      repeat (5) @(posedge clk);
      #1;
      rst_ni = 1'b0;
      @(negedge clk);
      check("t6_reset_outputs_zero", |{job_ready_o, ctrl_start_o, ctrl_M_size_o, ctrl_K_size_o,
            ctrl_N_size_o, cmpl_valid_o, cmpl_id_o, cmpl_err_o, cmpl_cycles_o, queue_level_o, idle_o}, 0);
      @(posedge clk); #1;
      rst_ni = 1'b1;
      exp_q.delete();
      delay_q.delete();
      @(negedge clk);
      check("t6_level", queue_level_o, 0);
      check("t6_idle", idle_o, 1);
      force_delay = 0;
      send_job(8, 4, 4, 4);
      wait_drain(300);

      // Random traffic
      rdy_always = 1'b0;
      for (int i = 0; i < 40; i++) begin
         repeat (int'($urandom_range(0, 3))) @(posedge clk);
         send_job(int'($urandom_range(0, 15)), rnd_size(), rnd_size(), rnd_size());
      end
      wait_drain(5000);
      check("final_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
